// File: rtl/ps2_keyboard_rx.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_rx
//
// Purpose:
//   Receives PS/2 keyboard frames and folds the E0 (extended) and F0 (release)
//   prefix bytes into single key events for the keyboard matrix logic.
//   Runs in the 35.468 MHz system clock domain. The PS/2 lines are input-only.
//
// Parameters:
//   FILTER   consecutive equal synced samples needed to accept a new ps2
//            clock level (>= 2)
//   TIMEOUT  cycles without a ps2 clock fall before a partial frame is
//            dropped (~1 ms at 35.468 MHz)
//
// Ports:
//   i_clock     system clock
//   i_reset     asynchronous, active-high reset
//   i_ps2[1:0]  [0]=ps2 clock, [1]=ps2 data; asynchronous, idle high
//   o_strobe    one-cycle pulse: a key event is valid on code/pressed/extended
//   o_code      scancode of the last event (held until the next event)
//   o_pressed   1=make, 0=break (an F0 prefix preceded the code)
//   o_extended  1=an E0 prefix preceded the code
//   o_error     one-cycle pulse: start-bit, parity or stop-bit failure
// ----------------------------------------------------------------------------
module ps2_keyboard_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 35468
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_ps2,
  output logic       o_strobe,
  output logic [7:0] o_code,
  output logic       o_pressed,
  output logic       o_extended,
  output logic       o_error
);

  localparam int FW = $clog2(FILTER);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          w_clk_s;
  logic          w_dat_s;
  logic          w_filt_flip;
  logic          w_fall;

  // Synchronisers come out of reset at the idle (high) line level so that
  // releasing reset never looks like a clock fall.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse the 2-FF chain.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2[0]};
      r_dat_sync <= {r_dat_sync[0], i_ps2[1]};
    end
  end

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  // r_filt_cnt counts consecutive synced samples that differ from the
  // accepted level; the level flips on the FILTER-th such sample.
  assign w_filt_flip = (w_clk_s != r_clk_filt) && (r_filt_cnt == FW'(FILTER - 1));
  assign w_fall      = w_filt_flip && r_clk_filt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_clk_filt <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shreg;
  logic          r_parity;
  logic [TW-1:0] r_tcnt;
  logic          w_tmo_hit;
  logic          w_shift;
  logic          w_start_err;
  logic          w_frame_end;
  logic          w_timeout;
  logic          w_frame_ok;

  assign w_tmo_hit = (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // A fall always wins over a coincident timeout: the bit it carries is real.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_start_err  = 1'b0;
    w_frame_end  = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall) begin
          if (!w_dat_s) w_state_next = DATA;
          else          w_start_err  = 1'b1;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift = 1'b1;
          if (r_bitcnt == 3'd7) w_state_next = PARITY;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_state_next = STOP;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_frame_end  = 1'b1;
          w_state_next = IDLE;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Stop bit is the data sampled on the current (stop) fall; odd parity means
  // the nine data+parity bits XOR to 1.
  assign w_frame_ok = w_dat_s && (^{r_shreg, r_parity});

  // --------------------------------------------------------------------------
  // Datapath, prefix flags and outputs
  // --------------------------------------------------------------------------
  logic r_ext_f;
  logic r_rel_f;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_bitcnt   <= '0;
      r_shreg    <= '0;
      r_parity   <= 1'b0;
      r_tcnt     <= '0;
      r_ext_f    <= 1'b0;
      r_rel_f    <= 1'b0;
      o_strobe   <= 1'b0;
      o_error    <= 1'b0;
      o_code     <= 8'h00;
      o_pressed  <= 1'b0;
      o_extended <= 1'b0;
    end else begin
      o_strobe <= 1'b0;
      o_error  <= 1'b0;

      if (r_state == IDLE) r_bitcnt <= '0;
      else if (w_shift)    r_bitcnt <= r_bitcnt + 3'd1;

      // Right shift: D0 arrives first and ends up in bit 0.
      if (w_shift) r_shreg <= {w_dat_s, r_shreg[7:1]};

      if (r_state == PARITY && w_fall) r_parity <= w_dat_s;

      // The watchdog only runs while a frame is in progress.
      if (w_fall || w_timeout || r_state == IDLE) r_tcnt <= '0;
      else                                        r_tcnt <= r_tcnt + TW'(1);

      if (w_start_err) o_error <= 1'b1;

      if (w_frame_end) begin
        if (w_frame_ok) begin
          unique case (r_shreg)
            8'hE0:   r_ext_f <= 1'b1;
            8'hF0:   r_rel_f <= 1'b1;
            default: begin
              o_strobe   <= 1'b1;
              o_code     <= r_shreg;
              o_pressed  <= ~r_rel_f;
              o_extended <= r_ext_f;
              r_ext_f    <= 1'b0;
              r_rel_f    <= 1'b0;
            end
          endcase
        end else begin
          // A corrupted byte may have been the key a prefix belonged to, so
          // the prefixes are dropped along with it.
          o_error <= 1'b1;
          r_ext_f <= 1'b0;
          r_rel_f <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_keyboard_rx
//
// Self-checking bench for ps2_keyboard_rx. A table of frames with expected
// events drives the main decode; hand-written sequences cover the start-bit
// error, timeout, clock glitches and reset mid-frame. Expected events go into
// a queue when a frame is sent and are popped when the DUT pulses.
// The PS/2 clock and TIMEOUT are scaled down to keep the run short.
// ----------------------------------------------------------------------------
module tb_ps2_keyboard_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 400;
  localparam int HALF    = 40;   // ps2 clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ps2 = 2'b11;
  logic       o_strobe;
  logic [7:0] o_code;
  logic       o_pressed;
  logic       o_extended;
  logic       o_error;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_ps2      (ps2),
    .o_strobe   (o_strobe),
    .o_code     (o_code),
    .o_pressed  (o_pressed),
    .o_extended (o_extended),
    .o_error    (o_error)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       pressed;
    logic       extended;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_any;
    logic       exp_err;
    logic [7:0] exp_code;
    logic       exp_pressed;
    logic       exp_ext;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  logic prev_pulse = 1'b0;
  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One ps2 bit: data set mid-high, clock low for HALF, back high. With
  // glitch set, sub-FILTER pulses are added in both clock phases.
  task automatic send_bit(input logic b, input logic glitch);
    ps2[1] = b;
    if (glitch) begin
      wait_cycles(5);
      ps2[0] = 1'b0;
      wait_cycles(FILTER - 3);
      ps2[0] = 1'b1;
      wait_cycles(HALF / 2 - 5 - (FILTER - 3));
    end else begin
      wait_cycles(HALF / 2);
    end
    ps2[0] = 1'b0;
    if (glitch) begin
      wait_cycles(15);
      ps2[0] = 1'b1;
      wait_cycles(FILTER - 3);
      ps2[0] = 1'b0;
      wait_cycles(HALF - 15 - (FILTER - 3));
    end else begin
      wait_cycles(HALF);
    end
    ps2[0] = 1'b1;
    wait_cycles(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic bad_stop, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit((~^d) ^ bad_par, glitch);
    send_bit(~bad_stop, glitch);
    ps2[1] = 1'b1;
    wait_cycles(2 * HALF);
  endtask

  // Start bit plus the first n data bits, then the lines go idle.
  task automatic send_partial(input logic [7:0] d, input int n);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i], 1'b0);
    ps2 = 2'b11;
  endtask

  task automatic expect_event(input logic [7:0] c, input logic p, input logic x);
    q.push_back('{1'b0, c, p, x});
  endtask

  task automatic expect_error();
    q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic bp, input logic bs,
                              input logic any, input logic err, input logic [7:0] c,
                              input logic p, input logic x);
    vec_t v;
    v.data = d; v.bad_par = bp; v.bad_stop = bs; v.exp_any = any;
    v.exp_err = err; v.exp_code = c; v.exp_pressed = p; v.exp_ext = x;
    return v;
  endfunction

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (o_strobe || o_error) begin
        check("strobe_error_overlap", {31'b0, o_strobe & o_error}, 0);
        check("pulse_one_cycle", {31'b0, prev_pulse}, 0);
        check("event_was_expected", {31'b0, q.size() != 0}, 1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("error_vs_strobe", {31'b0, o_error}, {31'b0, mon_e.is_err});
          if (!mon_e.is_err && o_strobe) begin
            check("code", {24'b0, o_code}, {24'b0, mon_e.code});
            check("pressed", {31'b0, o_pressed}, {31'b0, mon_e.pressed});
            check("extended", {31'b0, o_extended}, {31'b0, mon_e.extended});
          end
        end
      end
      prev_pulse = o_strobe | o_error;
    end
  end

  initial begin
    //            data   bpar  bstop any   err   code   press ext
    vecs[0]  = mk(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0);
    vecs[1]  = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[2]  = mk(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0);
    vecs[3]  = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[4]  = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[5]  = mk(8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b0, 1'b1);
    vecs[6]  = mk(8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, 1'b0);
    vecs[7]  = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[8]  = mk(8'h29, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    vecs[9]  = mk(8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 8'h29, 1'b1, 1'b0);
    vecs[10] = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[11] = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[12] = mk(8'h6B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6B, 1'b1, 1'b1);
    vecs[13] = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[14] = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[15] = mk(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0);
    vecs[16] = mk(8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE1, 1'b1, 1'b0);
    vecs[17] = mk(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
    vecs[18] = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[19] = mk(8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    vecs[20] = mk(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0);

    // Reset state
    rst = 1'b1;
    ps2 = 2'b11;
    wait_cycles(5);
    #1;
    check("reset_strobe", {31'b0, o_strobe}, 0);
    check("reset_error", {31'b0, o_error}, 0);
    check("reset_code", {24'b0, o_code}, 0);
    check("reset_pressed", {31'b0, o_pressed}, 0);
    check("reset_extended", {31'b0, o_extended}, 0);
    rst = 1'b0;
    wait_cycles(20);

    // Table-driven frames
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].exp_any) begin
        if (vecs[i].exp_err) expect_error();
        else expect_event(vecs[i].exp_code, vecs[i].exp_pressed, vecs[i].exp_ext);
      end
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 1'b0);
    end
    wait_drain();

    // Start bit of 1: a single fall with data high
    expect_error();
    send_bit(1'b1, 1'b0);
    wait_cycles(2 * HALF);
    expect_event(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Timeout after 5 data bits, then a clean frame
    send_partial(8'h5A, 5);
    wait_cycles(TIMEOUT + 200);
    expect_event(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // A timeout leaves a pending F0 in place
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_partial(8'hC3, 5);
    wait_cycles(TIMEOUT + 200);
    expect_event(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Sub-FILTER glitches on the ps2 clock in both phases
    send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
    expect_event(8'h12, 1'b1, 1'b1);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Reset mid-frame with F0 pending: outputs clear at once, flags drop
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_partial(8'h0F, 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_strobe", {31'b0, o_strobe}, 0);
    check("midreset_error", {31'b0, o_error}, 0);
    check("midreset_code", {24'b0, o_code}, 0);
    check("midreset_pressed", {31'b0, o_pressed}, 0);
    check("midreset_extended", {31'b0, o_extended}, 0);
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(20);
    expect_event(8'h12, 1'b1, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
